// File: rtl/clic_pkg.sv
// clic_pkg: shared constants and elaboration-time helpers for the CLIC arbiter.
//   MAX_VSCTXTS / MIN_VSCTXTS : supported range of virtual-supervisor contexts
//   VSID_W                    : width of a VS context identifier
//   ceildiv, ipow, clog_radix : constant functions used to size the max tree
package clic_pkg;

  localparam int unsigned MAX_VSCTXTS = 32;
  localparam int unsigned MIN_VSCTXTS = 4;
  localparam int unsigned VSID_W      = $clog2(MAX_VSCTXTS);

  function automatic int unsigned ceildiv(input int unsigned a, input int unsigned b);
    return (a + b - 1) / b;
  endfunction

  function automatic int unsigned ipow(input int unsigned base, input int unsigned exp);
    int unsigned r;
    r = 1;
    for (int unsigned k = 0; k < exp; k++) r = r * base;
    return r;
  endfunction

  // Smallest L with radix**L >= value.
  function automatic int unsigned clog_radix(input int unsigned value, input int unsigned radix);
    int unsigned lv;
    int unsigned span;
    lv   = 0;
    span = 1;
    while (span < value) begin
      span = span * radix;
      lv   = lv + 1;
    end
    return lv;
  endfunction

endpackage

// File: rtl/clic_vs_max_node.sv
// clic_vs_max_node: RADIX-input maximum selector on {valid, prio, id}.
//   clk_i, rst_i : clock, synchronous active-high reset (used only when REG=1)
//   valid_i      : per-input valid
//   prio_i/id_i  : per-input priority and source id (packed, input 0 at LSB)
//   valid_o      : any input valid
//   prio_o/id_o  : winner; higher {prio, id} wins, so priority ties go to the higher id
// REG=1 adds an output register, forming one pipeline stage of the tree.
module clic_vs_max_node #(
  parameter int unsigned RADIX  = 4,
  parameter int unsigned PRIO_W = 8,
  parameter int unsigned ID_W   = 8,
  parameter bit          REG    = 1'b0
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [RADIX-1:0]               valid_i,
  input  logic [RADIX-1:0][PRIO_W-1:0]   prio_i,
  input  logic [RADIX-1:0][ID_W-1:0]     id_i,
  output logic                           valid_o,
  output logic [PRIO_W-1:0]              prio_o,
  output logic [ID_W-1:0]                id_o
);

  logic              valid_d;
  logic [PRIO_W-1:0] prio_d;
  logic [ID_W-1:0]   id_d;

  always_comb begin
    valid_d = valid_i[0];
    prio_d  = prio_i[0];
    id_d    = id_i[0];
    for (int unsigned k = 1; k < RADIX; k++) begin
      if (valid_i[k] && (!valid_d || ({prio_i[k], id_i[k]} > {prio_d, id_d}))) begin
        valid_d = 1'b1;
        prio_d  = prio_i[k];
        id_d    = id_i[k];
      end
    end
  end

  if (REG) begin : g_reg
    logic              valid_q;
    logic [PRIO_W-1:0] prio_q;
    logic [ID_W-1:0]   id_q;

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        valid_q <= 1'b0;
        prio_q  <= '0;
        id_q    <= '0;
      end else begin
        valid_q <= valid_d;
        prio_q  <= prio_d;
        id_q    <= id_d;
      end
    end

    assign valid_o = valid_q;
    assign prio_o  = prio_q;
    assign id_o    = id_q;
  end else begin : g_comb
    logic unused_clk_rst;
    assign unused_clk_rst = clk_i ^ rst_i;
    assign valid_o = valid_d;
    assign prio_o  = prio_d;
    assign id_o    = id_d;
  end

endmodule

// File: rtl/clic_vs_arb_tree.sv
// clic_vs_arb_tree: per-hart CLIC arbiter with virtual-supervisor context filtering.
//   clk_i, rst_i       : clock, synchronous active-high reset
//   ip_i, ie_i         : per-source pending / enable
//   prio_i             : per-source priority, packed, source 0 at LSB
//   virt_i, vsid_i     : source delegated to a VS context, and its owning context
//   cur_vsid_i, vs_en_i: context running on the hart, hart is in a VS context
//   thresh_i           : winner must have prio > thresh_i
//   irq_valid_o/irq_ready_i : winner offer handshake
//   irq_id_o, irq_prio_o, irq_virt_o : offered winner
// Eligible sources feed a pipelined radix-RADIX max tree; its root drives an output
// register that never downgrades a pending offer but withdraws it when the root goes away.
module clic_vs_arb_tree
  import clic_pkg::*;
#(
  parameter int unsigned N_SOURCE    = 256,
  parameter int unsigned INTCTLBITS  = 8,
  parameter int unsigned NUM_VSCTXTS = 16,
  parameter int unsigned RADIX       = 4,
  parameter int unsigned PIPE_EVERY  = 2
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [N_SOURCE-1:0]            ip_i,
  input  logic [N_SOURCE-1:0]            ie_i,
  input  logic [N_SOURCE*INTCTLBITS-1:0] prio_i,
  input  logic [N_SOURCE-1:0]            virt_i,
  input  logic [N_SOURCE*VSID_W-1:0]     vsid_i,
  input  logic [VSID_W-1:0]              cur_vsid_i,
  input  logic                           vs_en_i,
  input  logic [INTCTLBITS-1:0]          thresh_i,
  output logic                           irq_valid_o,
  input  logic                           irq_ready_i,
  output logic [$clog2(N_SOURCE)-1:0]    irq_id_o,
  output logic [INTCTLBITS-1:0]          irq_prio_o,
  output logic                           irq_virt_o
);

  localparam int unsigned ID_W      = $clog2(N_SOURCE);
  localparam int unsigned LEVELS    = clog_radix(N_SOURCE, RADIX);
  localparam int unsigned N_LEAF    = ipow(RADIX, LEVELS);
  localparam int unsigned PE_SAFE   = (PIPE_EVERY == 0) ? 1 : PIPE_EVERY;
  localparam int unsigned PIPE_REGS = (PIPE_EVERY == 0) ? 0 : ceildiv(LEVELS, PE_SAFE) - 1;
  localparam int unsigned SUPP_LEN  = PIPE_REGS + 2;
  localparam int unsigned CNT_W     = $clog2(SUPP_LEN + 1);
  // All tree levels (leaves first, root last) live in one flat array.
  localparam int unsigned N_NODE    = (ipow(RADIX, LEVELS + 1) - 1) / (RADIX - 1);

  function automatic int unsigned lvl_off(input int unsigned lvl);
    int unsigned off;
    off = 0;
    for (int unsigned k = 0; k < lvl; k++) off = off + ipow(RADIX, LEVELS - k);
    return off;
  endfunction

  logic [N_NODE-1:0]                 t_valid;
  logic [N_NODE-1:0][INTCTLBITS-1:0] t_prio;
  logic [N_NODE-1:0][ID_W-1:0]       t_id;

  logic                  irq_valid_q, irq_valid_d;
  logic [ID_W-1:0]       irq_id_q, irq_id_d;
  logic [INTCTLBITS-1:0] irq_prio_q, irq_prio_d;
  logic                  irq_virt_q, irq_virt_d;
  logic [CNT_W-1:0]      supp_cnt_q, supp_cnt_d;
  logic [ID_W-1:0]       supp_id_q, supp_id_d;

  logic supp_active;
  assign supp_active = (supp_cnt_q != '0);

  // Leaves: eligibility filter for real sources, invalid padding beyond N_SOURCE.
  for (genvar i = 0; i < N_LEAF; i++) begin : g_leaf
    if (i < N_SOURCE) begin : g_src
      logic [VSID_W-1:0] vsid;
      logic              vs_match;
      logic              supp;
      assign vsid     = vsid_i[i*VSID_W +: VSID_W];
      // Context ids beyond NUM_VSCTXTS never match, even if cur_vsid_i equals them.
      assign vs_match = vs_en_i && (vsid == cur_vsid_i) && (32'(vsid) < NUM_VSCTXTS);
      assign supp     = supp_active && (supp_id_q == ID_W'(i));
      assign t_valid[i] = ip_i[i] && ie_i[i] && !supp && (!virt_i[i] || vs_match);
      assign t_prio[i]  = prio_i[i*INTCTLBITS +: INTCTLBITS];
      assign t_id[i]    = ID_W'(i);
    end else begin : g_pad
      assign t_valid[i] = 1'b0;
      assign t_prio[i]  = '0;
      assign t_id[i]    = '0;
    end
  end

  for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
    localparam int unsigned IN_OFF  = lvl_off(l);
    localparam int unsigned OUT_OFF = lvl_off(l + 1);
    localparam int unsigned N_OUT   = ceildiv(ipow(RADIX, LEVELS - l), RADIX);
    // The root level is never registered: the output register follows it.
    localparam bit DO_REG = (PIPE_EVERY != 0) && (((l + 1) % PE_SAFE) == 0) &&
                            (l + 1 < LEVELS);
    for (genvar j = 0; j < N_OUT; j++) begin : g_node
      clic_vs_max_node #(
        .RADIX  (RADIX),
        .PRIO_W (INTCTLBITS),
        .ID_W   (ID_W),
        .REG    (DO_REG)
      ) u_node (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .valid_i (t_valid[IN_OFF + j*RADIX +: RADIX]),
        .prio_i  (t_prio[IN_OFF + j*RADIX +: RADIX]),
        .id_i    (t_id[IN_OFF + j*RADIX +: RADIX]),
        .valid_o (t_valid[OUT_OFF + j]),
        .prio_o  (t_prio[OUT_OFF + j]),
        .id_o    (t_id[OUT_OFF + j])
      );
    end
  end

  logic                  root_valid;
  logic [INTCTLBITS-1:0] root_prio;
  logic [ID_W-1:0]       root_id;
  assign root_valid = t_valid[N_NODE-1];
  assign root_prio  = t_prio[N_NODE-1];
  assign root_id    = t_id[N_NODE-1];

  logic accept, root_block, root_take, downgrade;
  assign accept     = irq_valid_q && irq_ready_i;
  // In-flight tree copies of the accepted id must not be re-offered: block it both on the
  // accept edge itself and while the suppression window is open.
  assign root_block = (accept && (root_id == irq_id_q)) ||
                      (supp_active && (root_id == supp_id_q));
  assign root_take  = root_valid && (root_prio > thresh_i) && !root_block;
  assign downgrade  = irq_valid_q && !irq_ready_i &&
                      ({root_prio, root_id} < {irq_prio_q, irq_id_q});

  always_comb begin
    irq_valid_d = irq_valid_q;
    irq_id_d    = irq_id_q;
    irq_prio_d  = irq_prio_q;
    irq_virt_d  = irq_virt_q;
    if (!root_take) begin
      irq_valid_d = 1'b0;
    end else if (!downgrade) begin
      irq_valid_d = 1'b1;
      irq_id_d    = root_id;
      irq_prio_d  = root_prio;
      irq_virt_d  = virt_i[root_id];
    end
  end

  always_comb begin
    supp_cnt_d = supp_cnt_q;
    supp_id_d  = supp_id_q;
    if (accept) begin
      supp_cnt_d = CNT_W'(SUPP_LEN);
      supp_id_d  = irq_id_q;
    end else if (supp_active) begin
      supp_cnt_d = supp_cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      irq_valid_q <= 1'b0;
      irq_id_q    <= '0;
      irq_prio_q  <= '0;
      irq_virt_q  <= 1'b0;
      supp_cnt_q  <= '0;
      supp_id_q   <= '0;
    end else begin
      irq_valid_q <= irq_valid_d;
      irq_id_q    <= irq_id_d;
      irq_prio_q  <= irq_prio_d;
      irq_virt_q  <= irq_virt_d;
      supp_cnt_q  <= supp_cnt_d;
      supp_id_q   <= supp_id_d;
    end
  end

  assign irq_valid_o = irq_valid_q;
  assign irq_id_o    = irq_id_q;
  assign irq_prio_o  = irq_prio_q;
  assign irq_virt_o  = irq_virt_q;

endmodule

// File: tb/tb_clic_vs_arb_tree.sv
// Bench for clic_vs_arb_tree at default parameters (N=256, RADIX=4, PIPE_EVERY=2).
// LEVELS = 4, PIPE_REGS = ceil(4/2)-1 = 1, so input-to-output latency LAT = 2 cycles.
module tb_clic_vs_arb_tree;
  import clic_pkg::VSID_W;

  localparam int N   = 256;
  localparam int PW  = 8;
  localparam int LAT = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      ip, ie, virt;
  logic [N*PW-1:0]   prio;
  logic [N*VSID_W-1:0] vsid;
  logic [VSID_W-1:0] cur_vsid;
  logic              vs_en;
  logic [PW-1:0]     thresh;
  logic              irq_valid, irq_ready, irq_virt;
  logic [7:0]        irq_id;
  logic [PW-1:0]     irq_prio;

  always #5 clk = ~clk;

  clic_vs_arb_tree dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .ip_i        (ip),
    .ie_i        (ie),
    .prio_i      (prio),
    .virt_i      (virt),
    .vsid_i      (vsid),
    .cur_vsid_i  (cur_vsid),
    .vs_en_i     (vs_en),
    .thresh_i    (thresh),
    .irq_valid_o (irq_valid),
    .irq_ready_i (irq_ready),
    .irq_id_o    (irq_id),
    .irq_prio_o  (irq_prio),
    .irq_virt_o  (irq_virt)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct packed {
    logic       valid;
    logic [7:0] id;
    logic [7:0] prio;
    logic       virt;
  } offer_t;

  offer_t exp_q[$];
  string  tag_q[$];

  task automatic push_exp(input string tag, input logic v, input logic [7:0] id,
                          input logic [7:0] p, input logic vt);
    offer_t e;
    e.valid = v;
    e.id    = id;
    e.prio  = p;
    e.virt  = vt;
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic pop_cmp();
    offer_t e;
    string  t;
    if (exp_q.size() == 0) begin
      check_eq("sb_underflow", 32'd0, 32'd1);
      return;
    end
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    check_eq({t, "_valid"}, 32'(irq_valid), 32'(e.valid));
    if (e.valid) begin
      check_eq({t, "_id"}, 32'(irq_id), 32'(e.id));
      check_eq({t, "_prio"}, 32'(irq_prio), 32'(e.prio));
      check_eq({t, "_virt"}, 32'(irq_virt), 32'(e.virt));
    end
  endtask

  // Advance n active edges and park 1 time unit after the last one.
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_src(input int i, input logic [7:0] p, input logic vt,
                         input logic [VSID_W-1:0] vs);
    ip[i]                   = 1'b1;
    prio[i*PW +: PW]        = p;
    virt[i]                 = vt;
    vsid[i*VSID_W +: VSID_W] = vs;
  endtask

  task automatic clear_all(input string tag);
    ip = '0;
    push_exp(tag, 1'b0, 8'd0, 8'd0, 1'b0);
    cyc(LAT);
    pop_cmp();
  endtask

  initial begin
    rst       = 1'b1;
    ip        = '1;
    ie        = '1;
    virt      = '0;
    vsid      = '0;
    prio      = '0;
    for (int i = 0; i < N; i++) prio[i*PW +: PW] = 8'd1;
    cur_vsid  = '0;
    vs_en     = 1'b0;
    thresh    = '0;
    irq_ready = 1'b0;

    // Reset held with everything pending: never valid.
    for (int k = 0; k < 3; k++) begin
      cyc(1);
      check_eq("rst_hold", 32'(irq_valid), 32'd0);
    end
    rst = 1'b0;
    cyc(1);
    check_eq("rst_lat_early", 32'(irq_valid), 32'd0);
    push_exp("rst_first", 1'b1, 8'd255, 8'd1, 1'b0);
    cyc(1);
    pop_cmp();
    for (int i = 0; i < N; i++) prio[i*PW +: PW] = 8'd0;
    clear_all("clr0");

    // Priority with tie on prio 7: higher id wins.
    set_src(5, 8'd7, 1'b0, '0);
    set_src(200, 8'd7, 1'b0, '0);
    set_src(9, 8'd3, 1'b0, '0);
    push_exp("tie", 1'b1, 8'd200, 8'd7, 1'b0);
    cyc(LAT);
    pop_cmp();
    clear_all("clr1");

    // VS filter: src10 virt ctx3 prio9, src11 non-virt prio4, src12 virt ctx20 prio15.
    set_src(10, 8'd9, 1'b1, VSID_W'(3));
    set_src(11, 8'd4, 1'b0, '0);
    set_src(12, 8'd15, 1'b1, VSID_W'(20));
    cur_vsid = VSID_W'(3);
    vs_en    = 1'b1;
    push_exp("vs_match", 1'b1, 8'd10, 8'd9, 1'b1);
    cyc(LAT);
    pop_cmp();
    clear_all("clr2");
    ip[10] = 1'b1; ip[11] = 1'b1; ip[12] = 1'b1;
    cur_vsid = VSID_W'(2);
    push_exp("vs_other", 1'b1, 8'd11, 8'd4, 1'b0);
    cyc(LAT);
    pop_cmp();
    clear_all("clr3");
    ip[10] = 1'b1; ip[11] = 1'b1; ip[12] = 1'b1;
    cur_vsid = VSID_W'(3);
    vs_en    = 1'b0;
    push_exp("vs_off", 1'b1, 8'd11, 8'd4, 1'b0);
    cyc(LAT);
    pop_cmp();
    clear_all("clr4");
    ip[10] = 1'b1; ip[11] = 1'b1; ip[12] = 1'b1;
    cur_vsid = VSID_W'(20);
    vs_en    = 1'b1;
    push_exp("vs_range", 1'b1, 8'd11, 8'd4, 1'b0);
    cyc(LAT);
    pop_cmp();
    clear_all("clr5");
    virt = '0;

    // Threshold boundary and withdraw mid-offer.
    set_src(30, 8'd5, 1'b0, '0);
    thresh = 8'd4;
    push_exp("thr_above", 1'b1, 8'd30, 8'd5, 1'b0);
    cyc(LAT);
    pop_cmp();
    thresh = 8'd5;
    push_exp("thr_withdraw", 1'b0, 8'd0, 8'd0, 1'b0);
    cyc(LAT);
    pop_cmp();
    thresh = 8'd0;
    clear_all("clr6");

    // Suppression after accept of id 42 while its ip stays high two more cycles.
    set_src(42, 8'd8, 1'b0, '0);
    set_src(50, 8'd3, 1'b0, '0);
    push_exp("supp_pre", 1'b1, 8'd42, 8'd8, 1'b0);
    cyc(LAT);
    pop_cmp();
    irq_ready = 1'b1;
    cyc(1);
    irq_ready = 1'b0;
    check_eq("acc_drop", 32'(irq_valid), 32'd0);
    for (int k = 0; k < 5; k++) begin
      cyc(1);
      check_eq("supp_no42", 32'(irq_valid && (irq_id == 8'd42)), 32'd0);
      if (k == 1) ip[42] = 1'b0;
    end
    push_exp("supp_next", 1'b1, 8'd50, 8'd3, 1'b0);
    pop_cmp();
    ip[42] = 1'b1;
    push_exp("supp_expired", 1'b1, 8'd42, 8'd8, 1'b0);
    cyc(LAT);
    pop_cmp();
    clear_all("clr7");

    // No downgrade while offered; withdraw when root empties; upgrade allowed.
    set_src(7, 8'd6, 1'b0, '0);
    set_src(3, 8'd2, 1'b0, '0);
    push_exp("nd_pre", 1'b1, 8'd7, 8'd6, 1'b0);
    cyc(LAT);
    pop_cmp();
    ip[7] = 1'b0;
    for (int k = 0; k < LAT + 2; k++) begin
      cyc(1);
      check_eq("nd_hold_valid", 32'(irq_valid), 32'd1);
      check_eq("nd_hold_id", 32'(irq_id), 32'd7);
    end
    ip[3] = 1'b0;
    push_exp("nd_withdraw", 1'b0, 8'd0, 8'd0, 1'b0);
    cyc(LAT);
    pop_cmp();
    ip[3] = 1'b1;
    push_exp("nd_low", 1'b1, 8'd3, 8'd2, 1'b0);
    cyc(LAT);
    pop_cmp();
    set_src(100, 8'd9, 1'b0, '0);
    push_exp("upgrade", 1'b1, 8'd100, 8'd9, 1'b0);
    cyc(LAT);
    pop_cmp();

    // Reset mid-operation clears output in one cycle; first valid LAT cycles after release.
    rst = 1'b1;
    cyc(1);
    check_eq("midrst", 32'(irq_valid), 32'd0);
    rst = 1'b0;
    cyc(1);
    check_eq("midrst_lat", 32'(irq_valid), 32'd0);
    push_exp("midrst_first", 1'b1, 8'd100, 8'd9, 1'b0);
    cyc(1);
    pop_cmp();

    check_eq("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
